// File: rtl/uart_rx_irq_ctrl.sv
// rtl/uart_rx_irq_ctrl.sv - UART receive interrupt request controller with saturating pending count
// Optional build macro: UART_RX_IRQ_EDGE_EN (count rising edges of rx_update instead of high levels)
module uart_rx_irq_ctrl #(
    parameter int PEND_MAX = 1,
    parameter int CNT_W    = $clog2(PEND_MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_update,
    input  logic ack,
    output logic irr
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PEND_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ev;
    logic             rt;

`ifdef UART_RX_IRQ_EDGE_EN
    logic rx_q;

    // Remember last sampled rx_update so a held-high level yields one event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q <= 1'b0;
        end else begin
            rx_q <= rx_update;
        end
    end

    assign ev = rx_update && !rx_q;
`else
    assign ev = rx_update;
`endif

    // An ack only retires something when there is something to retire
    assign rt = ack && (pend_cnt != CNT_ZERO);

    // Next pending count: events add (saturating), retires subtract, both cancel
    always_comb begin
        cnt_nxt = pend_cnt;
        if (ev && !rt) begin
            if (pend_cnt != CNT_MAX) begin
                cnt_nxt = pend_cnt + CNT_ONE;
            end
        end else if (!ev && rt) begin
            cnt_nxt = pend_cnt - CNT_ONE;
        end
    end

    // Register the count and the request together so irr has no input-to-output path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_cnt <= CNT_ZERO;
            irr      <= 1'b0;
        end else begin
            pend_cnt <= cnt_nxt;
            irr      <= (cnt_nxt != CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_uart_rx_irq_ctrl.sv
// tb/tb_uart_rx_irq_ctrl.sv - directed self-checking bench for uart_rx_irq_ctrl
module tb_uart_rx_irq_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic rx_update;
    logic ack;
    logic irr;
    logic rx3;
    logic ack3;
    logic irr3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_irq_ctrl #(.PEND_MAX(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_update (rx_update),
        .ack       (ack),
        .irr       (irr)
    );

    uart_rx_irq_ctrl #(.PEND_MAX(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .rx_update (rx3),
        .ack       (ack3),
        .irr       (irr3)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle to the PEND_MAX=1 instance, return #1 after the edge
    task automatic step(input logic r, input logic a);
        rx_update = r;
        ack       = a;
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for one cycle to the PEND_MAX=3 instance
    task automatic step3(input logic r, input logic a);
        rx3  = r;
        ack3 = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        rx_update = 1'b0;
        ack       = 1'b0;
        rx3       = 1'b0;
        ack3      = 1'b0;

        #1;
        chk("reset_t0", irr, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            chk("reset_held", irr, 1'b0);
            chk("reset_held3", irr3, 1'b0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            chk("idle", irr, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("spurious_ack", irr, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            chk("spurious_idle", irr, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            chk("event_hold", irr, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            chk("event_keep", irr, 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("ack_clear", irr, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            chk("ack_idle", irr, 1'b0);
        end

        step(1'b0, 1'b1); chk("seq_ack0",  irr, 1'b0);
        step(1'b0, 1'b0); chk("seq_idle0", irr, 1'b0);
        step(1'b1, 1'b0); chk("seq_rx",    irr, 1'b1);
        step(1'b0, 1'b0); chk("seq_idle1", irr, 1'b1);
        step(1'b0, 1'b1); chk("seq_ack1",  irr, 1'b0);
        step(1'b0, 1'b0); chk("seq_idle2", irr, 1'b0);

        step(1'b1, 1'b1); chk("ev_ack_cnt0", irr, 1'b1);
        step(1'b0, 1'b0); chk("ev_ack_keep", irr, 1'b1);
        step(1'b0, 1'b1); chk("ev_ack_clr",  irr, 1'b0);

        step(1'b1, 1'b0); chk("async_pre", irr, 1'b1);
        step(1'b0, 1'b0); chk("async_pre2", irr, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_now", irr, 1'b0);
        @(posedge clk);
        #1;
        chk("async_held", irr, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0); chk("async_discard", irr, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step3(1'b1, 1'b0);
            chk("p3_hold", irr3, 1'b1);
        end
        step3(1'b0, 1'b1);
`ifdef UART_RX_IRQ_EDGE_EN
        chk("p3_ack1", irr3, 1'b0);
`else
        chk("p3_ack1", irr3, 1'b1);
`endif
        step3(1'b0, 1'b0);
        step3(1'b0, 1'b1);
`ifdef UART_RX_IRQ_EDGE_EN
        chk("p3_ack2", irr3, 1'b0);
`else
        chk("p3_ack2", irr3, 1'b1);
`endif
        step3(1'b0, 1'b0);
        step3(1'b0, 1'b1);
        chk("p3_ack3", irr3, 1'b0);
        step3(1'b0, 1'b1);
        chk("p3_underflow", irr3, 1'b0);
        chk("p1_quiet", irr, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_irq_ctrl.md
Name: uart_rx_irq_ctrl

Overview:
- UART receive-interrupt request controller between the UART receiver and the CPU interrupt logic.
- Records "new byte received" events (`rx_update`) in a saturating pending counter.
- Drives a level interrupt request `irr` while any event is pending; each CPU acknowledge (`ack`) retires one event.

Parameters:
- PEND_MAX, default 1: maximum number of pending events held; range 1..255.
- CNT_W, default $clog2(PEND_MAX+1): pending-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); clears all state immediately.
- rx_update  input  1  receive event from the UART receiver; sampled on every clk rising edge.
- ack  input  1  interrupt acknowledge from the CPU; sampled on every clk rising edge.
- irr  output  1  interrupt request; high while the pending count is nonzero.

Behaviour:
- State: pend_cnt (CNT_W bits) and irr, both registered.
- Reset (reset=0, asynchronous): pend_cnt=0, irr=0. Both stay 0 while reset is held.
- Event definition (default): ev = rx_update sampled high in that cycle (level-sensitive).
- Retire definition: rt = ack sampled high AND pend_cnt != 0.
- Next count, per clock edge:
  - ev && !rt: pend_cnt+1, saturating at PEND_MAX; an excess event is dropped silently.
  - !ev && rt: pend_cnt-1.
  - ev && rt: pend_cnt unchanged.
  - ev && ack with pend_cnt==0: becomes 1, because an event is never lost to a same-cycle ack.
  - neither: unchanged.
- irr is a registered copy of (next pend_cnt != 0), so it changes on the same edge as pend_cnt.
- Latency: rx_update high in cycle N gives irr=1 after the edge ending cycle N, i.e. one clock.
  - ack high in cycle N (count 1, no event) gives irr=0 after that same edge.
- ack with nothing pending is ignored: no underflow, irr stays 0.
- With PEND_MAX=1 and rx_update held high for several cycles, the count saturates at 1. A single one-cycle ack then drops irr to 0 if rx_update is low in that ack cycle.
- Reset asserted mid-operation discards all pending events immediately. Normal operation resumes on the first clock edge after reset deasserts.
- No combinational path from any input to irr.

Optional Feature:
- Macro: UART_RX_IRQ_EDGE_EN.
- Defined: ev = rising edge of rx_update (rx_update high now, low in the previous sampled cycle).
  - Adds one flop rx_q, reset to 0.
  - A held-high rx_update counts as exactly one event; irr latency stays one clock from the rising cycle.
- Undefined: level-sensitive ev as in Behaviour; no rx_q flop.
- All directed tests below with PEND_MAX=1 give identical results in both builds.
  - Exception: the PEND_MAX=3 hold test. Edge build counts 1 event; level build counts saturation to 3.

Test Plan:
- Reset and idle: reset=0 for 2 cycles, then 1, with rx_update=0 and ack=0 -> irr=0 throughout, including during reset.
- Spurious ack: ack=1 for 4 cycles with nothing pending -> irr=0 every cycle; then ack=0 for 4 cycles -> irr stays 0.
- Event and hold: rx_update=1 for 4 cycles -> irr=1 after the first edge and on all 4 checks. Then rx_update=0 for 4 cycles -> irr stays 1.
- Acknowledge: ack=1 for 4 cycles -> irr=0 from the first edge. Then idle 4 cycles -> irr=0.
- Single-cycle sequence: ack, idle, rx_update, idle, ack, idle (one cycle each) -> irr = 0, 0, 1, 1, 0, 0.
- Boundaries:
  - rx_update=1 and ack=1 in the same cycle with count 0 -> irr=1.
  - PEND_MAX=3, level build: rx_update held 5 cycles -> count saturates at 3. The third single-cycle ack then clears irr.
  - Asynchronous reset pulse while irr=1 -> irr=0 immediately, without waiting for a clock edge.
